uart_tx_byte: RTL
=================

# uart_tx_byte

Serial transmitter stage fed by the registered 8-bit output byte of the top-level I/O block. It accepts one byte per valid/ready handshake, then shifts it out on a single line as an asynchronous UART frame: start bit, 8 data bits LSB first, optional even-parity bit, one stop bit. The frame is timed by a programmable baud divider. The transmitter drives one dedicated output pin and exposes a busy flag for status.

## Interface
Parameters:
- CLKS_PER_BIT, default 434: clock cycles per serial bit (50 MHz / 115200). Legal range is 2..65535.
- PARITY_EN, default 0: 1 inserts an even-parity bit between data bit 7 and the stop bit.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  8  byte to transmit; sampled only on an accepting edge.
- data_valid  input  1  upstream has a byte on data_in.
- data_ready  output  1  transmitter can accept a byte; high exactly when the FSM is in IDLE.
- tx  output  1  serial line; idles high. Registered output, no combinational path from inputs.
- busy  output  1  high in every state except IDLE (equals ~data_ready).

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - state=IDLE, tx=1, data_ready=1, busy=0
  - baud counter=0, bit index=0, shift register=0
  - An aborted frame is never resumed.
- IDLE:
  - tx=1.
  - On an edge with data_valid && data_ready: latch data_in into the shift register, clear the baud counter and bit index, go to START, set tx=0.
  - data_in changes after the accepting edge have no effect.
- Baud counter: counts 0..CLKS_PER_BIT-1 in every non-IDLE state. Width is $clog2(CLKS_PER_BIT). The terminal count (CLKS_PER_BIT-1) ends the current bit.
- START:
  - At terminal count: go to DATA, tx = shift[0].
- DATA:
  - At terminal count: shift right by one, increment the 3-bit bit index, tx = next bit.
  - After bit index 7 completes: go to PARITY if PARITY_EN=1, else go to STOP. The tx value changes accordingly.
- PARITY:
  - tx = XOR of the 8 latched data bits, i.e. even parity over data plus parity bit.
  - At terminal count: go to STOP, tx=1.
- STOP:
  - tx=1.
  - At terminal count: go to IDLE.
- data_valid while busy is ignored. No byte is lost, because data_ready is low, so upstream must hold the byte.

## Timing
- Accepting edge = edge A. tx falls in the cycle immediately after A (latency 1).
- The start bit occupies cycles A+1 .. A+CLKS_PER_BIT.
- Data bit i occupies the CLKS_PER_BIT cycles starting at A+1+(i+1)*CLKS_PER_BIT.
- Frame length, A+1 through the end of stop: (10+PARITY_EN)*CLKS_PER_BIT cycles.
- data_ready rises in the cycle after the edge ending the stop bit (edge E).
- Back-to-back transfer with data_valid held high:
  - The next accept is at edge E+1.
  - The next start bit begins at E+2.
  - The line is therefore high for CLKS_PER_BIT+1 cycles between frames.
- data_valid rising on the same edge that the FSM enters IDLE is not accepted on that edge. data_ready is still low when that edge samples it.
- Bit-period accuracy is exact. There is no fractional divider; the error budget belongs to the choice of CLKS_PER_BIT.

## Test plan
- Reset values: hold rst_n=0 with random inputs -> tx=1, data_ready=1, busy=0 on every cycle.
- Single byte, CLKS_PER_BIT=4, PARITY_EN=0: send 0xA5 -> tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. data_ready returns high exactly 41 cycles after A.
- Parity, CLKS_PER_BIT=4, PARITY_EN=1:
  - Send 0xA5 -> parity bit 0.
  - Send 0x07 -> parity bit 1.
  - Frame is 44 cycles in each case.
- Back-to-back: hold data_valid=1, send 0x00 then 0xFF -> the second start edge occurs exactly CLKS_PER_BIT+1 cycles after the first stop bit begins. data_in toggling mid-frame does not corrupt either frame.
- Busy-ignore: pulse data_valid with 0x3C mid-frame -> no acceptance and no change to the frame in flight.
- Reset mid-frame: assert rst_n=0 during data bit 3 -> tx=1 asynchronously, before the next clock edge. After release, IDLE with data_ready=1, and the next byte 0x81 transmits correctly.

Source files
------------

// File: rtl/uart_tx_byte_if.sv
// rtl/uart_tx_byte_if.sv - byte handshake between the I/O block and the UART transmitter
interface uart_tx_byte_if;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;

   modport master (output data_in, output data_valid, input data_ready);
   modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - UART frame transmitter: start, 8 data LSB first, optional even parity, one stop
module uart_tx_byte #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter bit          PARITY_EN    = 1'b0
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_tx_byte_if.slave  bus,
   output logic           tx,
   output logic           busy
);
   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_q, par_d;
   logic            tx_q, tx_d;
   logic            at_last;

   assign at_last        = (cnt_q == LAST);
   assign bus.data_ready = (state_q == IDLE);
   assign busy           = (state_q != IDLE);
   assign tx             = tx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;

      if (state_q != IDLE) begin
         cnt_d = at_last ? '0 : cnt_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (bus.data_valid) begin
               // parity is captured here because the shift register is consumed bit by bit
               shift_d = bus.data_in;
               par_d   = ^bus.data_in;
               cnt_d   = '0;
               bit_d   = '0;
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (at_last) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (at_last) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = PARITY_EN ? PARITY : STOP;
                  tx_d    = PARITY_EN ? par_q : 1'b1;
               end else begin
                  tx_d = shift_q[1];
               end
            end
         end
         PARITY: begin
            if (at_last) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (at_last) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end
endmodule
